mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//   Parametrised arbiter between the CPU fetch (IF) port and data (MEM) port and the single MMU port.
//   Serialises accesses, holds MMU controls stable until mmu_mem_ready, and returns a one-cycle done pulse per access.
//   Selectable priority policy and an optional timeout that ends a hung access with an error.
//   Sits between the pipeline stages (IF/MEM) and the MMU; the hazard unit stalls on if_busy/mem_busy.
// PARAMETERS
//   XLEN           32  address/data width
//   DATA_PRIORITY  1   1: MEM wins when both requesters are pending; 0: round-robin
//   TIMEOUT_CYCLES 0   0: no timeout; N>0: abort after N wait cycles without ready (counter $clog2(N+1) bits)
// PORTS
//   clk                  in   1     clock, rising edge
//   reset_n              in   1     asynchronous, active-low reset
//   if_req               in   1     fetch request, held high until if_done
//   if_addr              in   XLEN  fetch address
//   if_done              out  1     1-cycle pulse: fetch complete
//   if_rdata             out  XLEN  instruction word, valid when if_done=1
//   if_err               out  1     with if_done: fetch timed out
//   if_busy              out  1     fetch pending or in flight
//   mem_req              in   1     data request, held high until mem_done
//   mem_we               in   1     1 write, 0 read
//   mem_signed           in   1     sign-extend read
//   mem_width            in   2     MMU width encoding (define.v)
//   mem_addr             in   XLEN  data address
//   mem_wdata            in   XLEN  store data
//   mem_done             out  1     1-cycle pulse: data access complete
//   mem_rdata            out  XLEN  load data, valid when mem_done=1 and mem_we=0
//   mem_err              out  1     with mem_done: access timed out
//   mem_busy             out  1     data request pending or in flight
//   mmu_mem_ready        in   1     MMU completes the current access in this cycle
//   mmu_data_out         in   XLEN  MMU read data, valid with mmu_mem_ready
//   mmu_read_enable      out  1     registered
//   mmu_write_enable     out  1     registered
//   mmu_mem_signed_read  out  1     registered
//   mmu_mem_data_width   out  2     registered
//   mmu_address          out  XLEN  registered
//   mmu_data_in          out  XLEN  registered
// BEHAVIOUR
// - Reset: every output and register is 0, including both data buses. FSM goes to IDLE; round-robin pointer selects IF.
//   Reset asserted mid-access drops the MMU enables immediately and emits no done pulse.
// - FSM states:
//     IDLE  -> FETCH or DATA on grant
//     FETCH -> IDLE on mmu_mem_ready or on timeout
//     DATA  -> IDLE on mmu_mem_ready or on timeout
// - Grant (IDLE only): a requester is eligible when its req=1 and its own done is 0 this cycle.
//   A req still high during the done cycle is not a new request.
//   Both requesters eligible:
//     DATA_PRIORITY=1: MEM wins.
//     DATA_PRIORITY=0: the requester not granted last wins; the pointer updates on every grant.
// - On the grant edge the MMU output registers load and stay constant until the access ends:
//     FETCH: read_enable=1, signed=0, width=`MMU_WIDTH_WORD, address=if_addr, data_in=0.
//     DATA:  write_enable=mem_we, read_enable=!mem_we, plus mem_signed, mem_width, mem_addr, mem_wdata.
// - Completion: on the edge where mmu_mem_ready=1 in FETCH/DATA:
//     the enables clear; the state returns to IDLE;
//     the matching done pulses for exactly 1 cycle; rdata captures mmu_data_out; err=0.
//   rdata holds until the next completion on that port. mmu_mem_ready in IDLE is ignored.
// - Latency: req at cycle 0 -> enables in cycle 1 -> ready in cycle 1 -> done in cycle 2.
//   Minimum spacing between two grants is 2 cycles (the IDLE/done cycle).
// - Timeout (TIMEOUT_CYCLES>0): the counter clears on grant and counts each FETCH/DATA cycle with ready=0.
//   When it reaches TIMEOUT_CYCLES: done=1, err=1, rdata=0, enables clear, state returns to IDLE.
//   If ready and the limit arrive in the same cycle, ready wins (err=0).
// - busy: if_busy = if_req | (state==FETCH); mem_busy = mem_req | (state==DATA). Both are forced to 0 in that port's done cycle.
// TESTING
// - Single fetch: if_addr=0x100, ready 2 cycles after enable, mmu_data_out=0x00500093 ->
//   read_enable high for 3 cycles; if_done pulse 1 cycle; if_rdata=0x00500093; if_err=0.
// - Collision, DATA_PRIORITY=1: if_req and mem_req (load, addr 0x2000) rise together ->
//   DATA serviced first; FETCH granted in the cycle after mem_done.
// - Round-robin, DATA_PRIORITY=0, both reqs held high for 4 accesses -> grant order IF, MEM, IF, MEM.
// - Store: mem_we=1, width=byte, addr=0x2003, wdata=0xAB ->
//   write_enable=1, read_enable=0, mmu_data_in=0xAB, mmu_address=0x2003 stable until ready.
// - Timeout, TIMEOUT_CYCLES=8, ready held 0 -> mem_done with mem_err=1 after 8 wait cycles; next request granted normally.
// - Reset in DATA with read_enable=1 -> all MMU outputs 0 immediately; no done pulse; state IDLE after reset release.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the IF/MEM pipeline requesters, the access controller
// and the MMU. The controller uses the slave view; the environment that
// drives requests and plays the MMU uses the master view.
`timescale 1ns/1ps
interface mem_access_ctrl_if #(
  parameter int XLEN = 32
);
  // fetch port
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_done;
  logic [XLEN-1:0] if_rdata;
  logic            if_err;
  logic            if_busy;
  // data port
  logic            mem_req;
  logic            mem_we;
  logic            mem_signed;
  logic [1:0]      mem_width;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_done;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;
  logic            mem_busy;
  // MMU port
  logic            mmu_mem_ready;
  logic [XLEN-1:0] mmu_data_out;
  logic            mmu_read_enable;
  logic            mmu_write_enable;
  logic            mmu_mem_signed_read;
  logic [1:0]      mmu_mem_data_width;
  logic [XLEN-1:0] mmu_address;
  logic [XLEN-1:0] mmu_data_in;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_signed, mem_width, mem_addr, mem_wdata,
    input  mmu_mem_ready, mmu_data_out,
    output if_done, if_rdata, if_err, if_busy,
    output mem_done, mem_rdata, mem_err, mem_busy,
    output mmu_read_enable, mmu_write_enable, mmu_mem_signed_read,
    output mmu_mem_data_width, mmu_address, mmu_data_in
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_signed, mem_width, mem_addr, mem_wdata,
    output mmu_mem_ready, mmu_data_out,
    input  if_done, if_rdata, if_err, if_busy,
    input  mem_done, mem_rdata, mem_err, mem_busy,
    input  mmu_read_enable, mmu_write_enable, mmu_mem_signed_read,
    input  mmu_mem_data_width, mmu_address, mmu_data_in
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Arbiter that serialises CPU fetch and data accesses onto the single MMU
// port. MMU controls are registered on grant and held until the MMU
// reports ready (or the optional wait limit expires); each access ends with
// a one-cycle done pulse on the port that issued it.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int XLEN           = 32,
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic              clk,
  input logic              reset_n,
  mem_access_ctrl_if.slave bus
);

  localparam logic [1:0] MMU_WIDTH_WORD = 2'b10;
  // A zero-width counter is illegal, so keep one bit when the timeout is off.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            prefer_mem_q, prefer_mem_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic            if_done_q, if_done_d;
  logic            if_err_q, if_err_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic            mem_done_q, mem_done_d;
  logic            mem_err_q, mem_err_d;
  logic [XLEN-1:0] mem_rdata_q, mem_rdata_d;

  logic            mmu_re_q, mmu_re_d;
  logic            mmu_we_q, mmu_we_d;
  logic            mmu_signed_q, mmu_signed_d;
  logic [1:0]      mmu_width_q, mmu_width_d;
  logic [XLEN-1:0] mmu_addr_q, mmu_addr_d;
  logic [XLEN-1:0] mmu_wdata_q, mmu_wdata_d;

  logic if_elig, mem_elig, grant_if, grant_mem, timeout_hit, finish;

  // Next-state, grant, MMU register loading and completion/timeout handling
  always_comb begin
    state_d      = state_q;
    prefer_mem_d = prefer_mem_q;
    wait_cnt_d   = wait_cnt_q;
    if_done_d    = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_done_d   = 1'b0;
    mem_err_d    = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    mmu_re_d     = mmu_re_q;
    mmu_we_d     = mmu_we_q;
    mmu_signed_d = mmu_signed_q;
    mmu_width_d  = mmu_width_q;
    mmu_addr_d   = mmu_addr_q;
    mmu_wdata_d  = mmu_wdata_q;
    grant_if     = 1'b0;
    grant_mem    = 1'b0;
    timeout_hit  = 1'b0;

    // A request still high in its own done cycle is the old one, not a new one.
    if_elig  = bus.if_req & ~if_done_q;
    mem_elig = bus.mem_req & ~mem_done_q;

    if (if_elig && mem_elig) begin
      if (DATA_PRIORITY != 0) grant_mem = 1'b1;
      else if (prefer_mem_q)  grant_mem = 1'b1;
      else                    grant_if  = 1'b1;
    end else begin
      grant_if  = if_elig;
      grant_mem = mem_elig;
    end

    // Ready in the same cycle as the limit completes normally.
    if (TIMEOUT_CYCLES > 0)
      timeout_hit = ~bus.mmu_mem_ready &&
                    ((wait_cnt_q + 1'b1) == CNT_W'(TIMEOUT_CYCLES));
    finish = bus.mmu_mem_ready | timeout_hit;

    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (grant_mem) begin
          state_d      = ST_DATA;
          prefer_mem_d = 1'b0;
          mmu_re_d     = ~bus.mem_we;
          mmu_we_d     = bus.mem_we;
          mmu_signed_d = bus.mem_signed;
          mmu_width_d  = bus.mem_width;
          mmu_addr_d   = bus.mem_addr;
          mmu_wdata_d  = bus.mem_wdata;
        end else if (grant_if) begin
          state_d      = ST_FETCH;
          prefer_mem_d = 1'b1;
          mmu_re_d     = 1'b1;
          mmu_we_d     = 1'b0;
          mmu_signed_d = 1'b0;
          mmu_width_d  = MMU_WIDTH_WORD;
          mmu_addr_d   = bus.if_addr;
          mmu_wdata_d  = '0;
        end
      end
      ST_FETCH: begin
        if (finish) begin
          state_d    = ST_IDLE;
          mmu_re_d   = 1'b0;
          mmu_we_d   = 1'b0;
          if_done_d  = 1'b1;
          if_err_d   = ~bus.mmu_mem_ready;
          if_rdata_d = bus.mmu_mem_ready ? bus.mmu_data_out : '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (finish) begin
          state_d     = ST_IDLE;
          mmu_re_d    = 1'b0;
          mmu_we_d    = 1'b0;
          mem_done_d  = 1'b1;
          mem_err_d   = ~bus.mmu_mem_ready;
          mem_rdata_d = bus.mmu_mem_ready ? bus.mmu_data_out : '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mmu_re_d = 1'b0;
        mmu_we_d = 1'b0;
      end
    endcase
  end

  // State, arbitration pointer, wait counter and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      prefer_mem_q <= 1'b0;
      wait_cnt_q   <= '0;
      if_done_q    <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      mem_done_q   <= 1'b0;
      mem_err_q    <= 1'b0;
      mem_rdata_q  <= '0;
      mmu_re_q     <= 1'b0;
      mmu_we_q     <= 1'b0;
      mmu_signed_q <= 1'b0;
      mmu_width_q  <= 2'b00;
      mmu_addr_q   <= '0;
      mmu_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      prefer_mem_q <= prefer_mem_d;
      wait_cnt_q   <= wait_cnt_d;
      if_done_q    <= if_done_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      mem_done_q   <= mem_done_d;
      mem_err_q    <= mem_err_d;
      mem_rdata_q  <= mem_rdata_d;
      mmu_re_q     <= mmu_re_d;
      mmu_we_q     <= mmu_we_d;
      mmu_signed_q <= mmu_signed_d;
      mmu_width_q  <= mmu_width_d;
      mmu_addr_q   <= mmu_addr_d;
      mmu_wdata_q  <= mmu_wdata_d;
    end
  end

  assign bus.if_done             = if_done_q;
  assign bus.if_err              = if_err_q;
  assign bus.if_rdata            = if_rdata_q;
  assign bus.mem_done            = mem_done_q;
  assign bus.mem_err             = mem_err_q;
  assign bus.mem_rdata           = mem_rdata_q;
  assign bus.mmu_read_enable     = mmu_re_q;
  assign bus.mmu_write_enable    = mmu_we_q;
  assign bus.mmu_mem_signed_read = mmu_signed_q;
  assign bus.mmu_mem_data_width  = mmu_width_q;
  assign bus.mmu_address         = mmu_addr_q;
  assign bus.mmu_data_in         = mmu_wdata_q;
  // Busy drops in the done cycle so the hazard unit can release the stage.
  assign bus.if_busy  = (bus.if_req  | (state_q == ST_FETCH)) & ~if_done_q;
  assign bus.mem_busy = (bus.mem_req | (state_q == ST_DATA))  & ~mem_done_q;

endmodule
